// File: rtl/gate_identifier_pkg.sv
// Shared types and constants for the 2-input gate identifier: FSM states,
// classification codes and the reference truth tables (bit k = y for {a,b}=k).
package gate_identifier_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPLE1,
      SAMPLE2,
      DONE
   } state_t;

   typedef enum logic [2:0] {
      CLS_UNKNOWN = 3'd0,
      CLS_AND     = 3'd1,
      CLS_OR      = 3'd2,
      CLS_NAND    = 3'd3,
      CLS_NOR     = 3'd4,
      CLS_XOR     = 3'd5,
      CLS_XNOR    = 3'd6,
      CLS_CONST   = 3'd7
   } cls_t;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_identifier_classifier.sv
// Combinational map from a sampled 4-entry truth table to a gate class code;
// an unstable measurement is never trusted and always yields UNKNOWN.
module gate_classifier
   import gate_identifier_pkg::*;
(
   input  logic [3:0] truth_i,
   input  logic       unstable_i,
   output logic [2:0] class_o
);

   cls_t cls;

   always_comb begin
      cls = CLS_UNKNOWN;
      if (!unstable_i) begin
         case (truth_i)
            TT_AND:           cls = CLS_AND;
            TT_OR:            cls = CLS_OR;
            TT_NAND:          cls = CLS_NAND;
            TT_NOR:           cls = CLS_NOR;
            TT_XOR:           cls = CLS_XOR;
            TT_XNOR:          cls = CLS_XNOR;
            4'b0000, 4'b1111: cls = CLS_CONST;
            default:          cls = CLS_UNKNOWN;
         endcase
      end
   end

   assign class_o = cls;

endmodule

// File: rtl/gate_identifier.sv
// Drives all four input vectors into a 2-input gate, samples its output twice
// per vector after a settle period, and reports the truth table and gate class.
module gate_identifier
   import gate_identifier_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_dut_y,
   output logic       o_dut_a,
   output logic       o_dut_b,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_valid,
   output logic [3:0] o_truth,
   output logic [2:0] o_class,
   output logic       o_unstable
);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dut_a_q, dut_a_d;
   logic             dut_b_q, dut_b_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;
   logic [3:0]       truth_q, truth_d;
   logic [2:0]       class_q, class_d;
   logic             unstable_q, unstable_d;
   logic [2:0]       class_w;

   gate_classifier u_classifier (
      .truth_i    (truth_q),
      .unstable_i (unstable_q),
      .class_o    (class_w)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         vec_q      <= '0;
         cnt_q      <= '0;
         dut_a_q    <= 1'b0;
         dut_b_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         truth_q    <= '0;
         class_q    <= '0;
         unstable_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         dut_a_q    <= dut_a_d;
         dut_b_q    <= dut_b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         valid_q    <= valid_d;
         truth_q    <= truth_d;
         class_q    <= class_d;
         unstable_q <= unstable_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      cnt_d      = cnt_q;
      dut_a_d    = dut_a_q;
      dut_b_d    = dut_b_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      valid_d    = valid_q;
      truth_d    = truth_q;
      class_d    = class_q;
      unstable_d = unstable_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d            = SETTLE;
               vec_d              = '0;
               cnt_d              = '0;
               {dut_a_d, dut_b_d} = 2'b00;
               busy_d             = 1'b1;
               valid_d            = 1'b0;
               truth_d            = '0;
               unstable_d         = 1'b0;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE1;
            end
         end
         SAMPLE1: begin
            truth_d[vec_q] = i_dut_y;
            state_d        = SAMPLE2;
         end
         SAMPLE2: begin
            // truth_q[vec_q] already holds the first sample taken one cycle ago
            if (i_dut_y != truth_q[vec_q]) begin
               unstable_d = 1'b1;
            end
            if (vec_q == 2'd3) begin
               state_d = DONE;
            end else begin
               vec_d              = vec_q + 2'd1;
               cnt_d              = '0;
               {dut_a_d, dut_b_d} = vec_q + 2'd1;
               state_d            = SETTLE;
            end
         end
         DONE: begin
            done_d             = 1'b1;
            valid_d            = 1'b1;
            busy_d             = 1'b0;
            class_d            = class_w;
            {dut_a_d, dut_b_d} = 2'b00;
            state_d            = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_dut_a    = dut_a_q;
   assign o_dut_b    = dut_b_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_valid    = valid_q;
   assign o_truth    = truth_q;
   assign o_class    = class_q;
   assign o_unstable = unstable_q;

endmodule

// File: tb/tb_gate_identifier.sv
// Self-checking bench: a behavioural gate model answers the identifier's vectors;
// expected tables and classes are derived from the gate functions themselves.
module tb_gate_identifier;

   localparam int EXP_LAT = 17;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       dut_y;
   logic       dut_a, dut_b;
   logic       busy, done, valid, unstable;
   logic [3:0] truth;
   logic [2:0] cls;

   logic [3:0] tt;
   logic       glitch;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign dut_y = tt[{dut_a, dut_b}] ^ glitch;

   gate_identifier #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_dut_y    (dut_y),
      .o_dut_a    (dut_a),
      .o_dut_b    (dut_b),
      .o_busy     (busy),
      .o_done     (done),
      .o_valid    (valid),
      .o_truth    (truth),
      .o_class    (cls),
      .o_unstable (unstable)
   );

   // 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 8 y=a
   function automatic logic gate_fn(input int g, input logic a, input logic b);
      case (g)
         1: return a & b;
         2: return a | b;
         3: return ~(a & b);
         4: return ~(a | b);
         5: return a ^ b;
         6: return ~(a ^ b);
         8: return a;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] tt_of(input int g);
      logic [3:0] r;
      logic [1:0] kv;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         kv = 2'(k);
         r[k] = gate_fn(g, kv[1], kv[0]);
      end
      return r;
   endfunction

   function automatic logic [2:0] ref_class(input logic [3:0] t, input logic u);
      if (u) return 3'd0;
      if (t == 4'h0 || t == 4'hF) return 3'd7;
      for (int g = 1; g <= 6; g++) begin
         if (tt_of(g) == t) return 3'(g);
      end
      return 3'd0;
   endfunction

   // Pulses start, returns edges from acceptance to o_done (-1 on timeout) and
   // o_busy as seen the cycle before. gc: cycle with a glitched y; sc: extra start.
   task automatic run(input int gc, input int sc, output int lat, output logic busy_pre);
      logic prev_busy;
      lat      = -1;
      busy_pre = 1'b0;
      start    = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      prev_busy = busy;
      for (int n = 1; n <= 40; n++) begin
         glitch = ((n - 1) == gc);
         start  = ((n - 1) == sc);
         @(posedge clk); #1;
         if (done) begin
            lat      = n;
            busy_pre = prev_busy;
            break;
         end
         prev_busy = busy;
      end
      glitch = 1'b0;
      start  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; glitch = 1'b0; tt = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({dut_a, dut_b, busy, done, valid, truth, cls, unstable} !== 14'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b want=0", {dut_a, dut_b, busy, done, valid, truth, cls, unstable});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_gates();
      int lat;
      logic bp;
      int gl[3] = '{3, 5, 1};
      foreach (gl[i]) begin
         tt = tt_of(gl[i]);
         run(-1, -1, lat, bp);
         checks++;
         if (lat != EXP_LAT) begin errors++; $display("FAIL gate%0d_latency got=%0d want=%0d", gl[i], lat, EXP_LAT); end
         checks++;
         if (truth !== tt) begin errors++; $display("FAIL gate%0d_truth got=%b want=%b", gl[i], truth, tt); end
         checks++;
         if (cls !== ref_class(tt, 1'b0)) begin errors++; $display("FAIL gate%0d_class got=%0d want=%0d", gl[i], cls, ref_class(tt, 1'b0)); end
         checks++;
         if ({unstable, valid, busy, bp} !== 4'b0101) begin
            errors++;
            $display("FAIL gate%0d_flags unstable,valid,busy,busy_pre got=%b want=0101", gl[i], {unstable, valid, busy, bp});
         end
         @(posedge clk); #1;
         checks++;
         if ({done, valid, dut_a, dut_b} !== 4'b0100 || truth !== tt) begin
            errors++;
            $display("FAIL gate%0d_hold done,valid,a,b got=%b want=0100 truth=%b", gl[i], {done, valid, dut_a, dut_b}, truth);
         end
      end
   endtask

   task automatic test_const_unknown();
      int lat;
      logic bp;
      logic [3:0] pats[3];
      pats[0] = 4'b1111;
      pats[1] = tt_of(8);
      pats[2] = 4'b0011;
      foreach (pats[i]) begin
         tt = pats[i];
         run(-1, -1, lat, bp);
         checks++;
         if (truth !== tt || cls !== ref_class(tt, 1'b0) || lat != EXP_LAT) begin
            errors++;
            $display("FAIL pattern_%b truth=%b class=%0d lat=%0d want class=%0d lat=%0d", tt, truth, cls, lat, ref_class(tt, 1'b0), EXP_LAT);
         end
      end
   endtask

   task automatic test_unstable();
      int lat;
      logic bp;
      tt = tt_of(3);
      // vector 2 second sample happens in cycle 2*(2+2)+2+1 = 11 after acceptance
      run(11, -1, lat, bp);
      checks++;
      if (lat != EXP_LAT) begin errors++; $display("FAIL unstable_latency got=%0d want=%0d", lat, EXP_LAT); end
      checks++;
      if (unstable !== 1'b1 || cls !== ref_class(tt, 1'b1) || truth !== tt) begin
         errors++;
         $display("FAIL unstable_result unstable=%b class=%0d truth=%b want 1 %0d %b", unstable, cls, truth, ref_class(tt, 1'b1), tt);
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      int extra;
      logic bp;
      tt = tt_of(4);
      run(-1, 5, lat, bp);
      checks++;
      if (lat != EXP_LAT || cls !== ref_class(tt, 1'b0)) begin
         errors++;
         $display("FAIL ignored_start lat=%0d class=%0d want %0d %0d", lat, cls, EXP_LAT, ref_class(tt, 1'b0));
      end
      extra = 0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk); #1;
         if (done || busy) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL ignored_start_requeue got=%0d busy/done cycles want=0", extra); end
   endtask

   task automatic test_back_to_back();
      int lat;
      int lat2;
      logic bp;
      tt = tt_of(6);
      start = 1'b1;
      lat = -1;
      @(posedge clk); #1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done) begin lat = n; break; end
      end
      checks++;
      if (lat != EXP_LAT) begin errors++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, EXP_LAT); end
      lat2 = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            checks++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
               errors++;
               $display("FAIL b2b_accept busy=%b valid=%b want 1 0", busy, valid);
            end
            start = 1'b0;
         end
         if (done) begin lat2 = n; break; end
      end
      start = 1'b0;
      checks++;
      if (lat2 != EXP_LAT + 1 || truth !== tt || cls !== ref_class(tt, 1'b0)) begin
         errors++;
         $display("FAIL b2b_second lat=%0d truth=%b class=%0d want %0d %b %0d", lat2, truth, cls, EXP_LAT + 1, tt, ref_class(tt, 1'b0));
      end
   endtask

   task automatic test_reset_midrun();
      int dn;
      int lat;
      logic bp;
      tt = tt_of(2);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({dut_a, dut_b, busy, done, valid, truth, cls, unstable} !== 14'b0) begin
         errors++;
         $display("FAIL midrun_reset got=%b want=0", {dut_a, dut_b, busy, done, valid, truth, cls, unstable});
      end
      rst_n = 1'b1;
      dn = 0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk); #1;
         if (done || busy) dn++;
      end
      checks++;
      if (dn != 0) begin errors++; $display("FAIL midrun_no_done got=%0d want=0", dn); end
      tt = tt_of(5);
      run(-1, -1, lat, bp);
      checks++;
      if (lat != EXP_LAT || truth !== tt || cls !== ref_class(tt, 1'b0)) begin
         errors++;
         $display("FAIL midrun_restart lat=%0d truth=%b class=%0d want %0d %b %0d", lat, truth, cls, EXP_LAT, tt, ref_class(tt, 1'b0));
      end
   endtask

   task automatic test_random();
      int lat;
      logic bp;
      for (int i = 0; i < 10; i++) begin
         tt = 4'($urandom_range(0, 15));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         run(-1, -1, lat, bp);
         checks++;
         if (lat != EXP_LAT || truth !== tt || cls !== ref_class(tt, 1'b0) || unstable !== 1'b0) begin
            errors++;
            $display("FAIL random%0d lat=%0d truth=%b class=%0d unstable=%b want %0d %b %0d 0",
                     i, lat, truth, cls, unstable, EXP_LAT, tt, ref_class(tt, 1'b0));
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_gates();
      test_const_unknown();
      test_unstable();
      test_start_ignored();
      test_back_to_back();
      test_reset_midrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
